neuron_param_loader: RTL

Byte-serial configuration loader that sits directly upstream of the single-channel dual-leak ALIF neuron. It drives the neuron's `weight_a`, `leak_rate_1`, `leak_rate_2`, `threshold_min`, `leak_cycles_1`, `leak_cycles_2` and `params_ready` inputs. It accepts a 6-byte frame (5 payload bytes plus an XOR checksum), holds the frame in shadow registers, and commits it to the outputs atomically only when the checksum passes. The neuron therefore never sees a partially loaded parameter set.

---
 rtl/neuron_param_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/neuron_param_loader.sv
`timescale 1ns/1ps
// ============================================================================
// neuron_param_loader
//
// Byte-serial configuration loader for the single-channel dual-leak ALIF
// neuron. It accepts a 6-byte frame: five payload bytes followed by an XOR
// checksum. The payload is held in shadow registers and is copied to the
// neuron-facing outputs in one step, and only when the checksum matches. The
// neuron therefore never sees a partially loaded parameter set.
//
// Frame layout:
//   byte0[2:0] -> weight_a       (byte0[7:3] are covered by the checksum only)
//   byte1      -> leak_rate_1
//   byte2      -> leak_rate_2
//   byte3      -> threshold_min
//   byte4[3:0] -> leak_cycles_1
//   byte4[7:4] -> leak_cycles_2
//   byte5      -> XOR of bytes 0..4
//
// Parameters:
//   TIMEOUT        idle cycles allowed between accepted bytes before abort
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   start          one-cycle frame start; restarts a frame already in progress
//   data_in        frame byte
//   data_valid     data_in is valid this cycle
//   busy           high while a frame is being loaded
//   params_ready   a valid parameter set has been committed since reset
//   load_done      one-cycle pulse on a successful commit
//   load_err       sticky checksum/timeout error, cleared by start or reset
//   weight_a .. leak_cycles_2   committed parameter set
// ============================================================================
module neuron_param_loader #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       busy,
    output logic       params_ready,
    output logic       load_done,
    output logic       load_err,
    output logic [2:0] weight_a,
    output logic [7:0] leak_rate_1,
    output logic [7:0] leak_rate_2,
    output logic [7:0] threshold_min,
    output logic [3:0] leak_cycles_1,
    output logic [3:0] leak_cycles_2
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd5;

    state_t          r_state;
    logic [2:0]      r_idx;
    logic [7:0]      r_csum;
    logic [7:0]      r_tmo;
    logic [4:0][7:0] r_shadow;

    logic            r_busy;
    logic            r_params_ready;
    logic            r_load_done;
    logic            r_load_err;
    logic [2:0]      r_weight_a;
    logic [7:0]      r_leak_rate_1;
    logic [7:0]      r_leak_rate_2;
    logic [7:0]      r_threshold_min;
    logic [3:0]      r_leak_cycles_1;
    logic [3:0]      r_leak_cycles_2;

    logic [7:0]      w_tmo_next;

    // The abort fires on the edge where the idle count would reach TIMEOUT,
    // i.e. TIMEOUT idle cycles after start or the last accepted byte.
    assign w_tmo_next = r_tmo + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_csum          <= '0;
            r_tmo           <= '0;
            r_shadow        <= '0;
            r_busy          <= 1'b0;
            r_params_ready  <= 1'b0;
            r_load_done     <= 1'b0;
            r_load_err      <= 1'b0;
            r_weight_a      <= '0;
            r_leak_rate_1   <= '0;
            r_leak_rate_2   <= '0;
            r_threshold_min <= '0;
            r_leak_cycles_1 <= '0;
            r_leak_cycles_2 <= '0;
        end else begin
            r_load_done <= 1'b0;

            // start outranks data_valid: a byte presented with start is dropped
            if (start) begin
                r_state    <= S_LOAD;
                r_busy     <= 1'b1;
                r_idx      <= '0;
                r_csum     <= '0;
                r_tmo      <= '0;
                r_load_err <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // data_valid is ignored outside a frame
                        r_busy <= 1'b0;
                    end

                    S_LOAD: begin
                        if (data_valid) begin
                            r_tmo <= '0;
                            if (r_idx == LAST_IDX) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_idx   <= '0;
                                if (r_csum == data_in) begin
                                    r_weight_a      <= r_shadow[0][2:0];
                                    r_leak_rate_1   <= r_shadow[1];
                                    r_leak_rate_2   <= r_shadow[2];
                                    r_threshold_min <= r_shadow[3];
                                    r_leak_cycles_1 <= r_shadow[4][3:0];
                                    r_leak_cycles_2 <= r_shadow[4][7:4];
                                    r_params_ready  <= 1'b1;
                                    r_load_done     <= 1'b1;
                                end else begin
                                    r_load_err <= 1'b1;
                                end
                            end else begin
                                r_shadow[r_idx] <= data_in;
                                r_csum          <= r_csum ^ data_in;
                                r_idx           <= r_idx + 3'd1;
                            end
                        end else if (w_tmo_next == TIMEOUT) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_idx      <= '0;
                            r_tmo      <= '0;
                            r_shadow   <= '0;
                            r_load_err <= 1'b1;
                        end else begin
                            r_tmo <= w_tmo_next;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy          = r_busy;
    assign params_ready  = r_params_ready;
    assign load_done     = r_load_done;
    assign load_err      = r_load_err;
    assign weight_a      = r_weight_a;
    assign leak_rate_1   = r_leak_rate_1;
    assign leak_rate_2   = r_leak_rate_2;
    assign threshold_min = r_threshold_min;
    assign leak_cycles_1 = r_leak_cycles_1;
    assign leak_cycles_2 = r_leak_cycles_2;

endmodule
